// File: rtl/rx_triggered_capture.sv
// rx_triggered_capture
//   Captures a triggered burst of parallel ADC sample words into a local
//   buffer, then streams the burst out as one AXI-stream packet.
//   Everything runs in the ADC clock domain.
//
// Ports
//   adc_clk, adc_reset_n          clock, synchronous active-low reset
//   adc_data_in/adc_valid_in      ADC parallel sample word + qualifier
//   adc_trigger                   capture trigger (pulse or level)
//   cfg_length_*                  AXIS capture length in words (IDLE only)
//   cfg_start_stop_*              AXIS control: bit0 arm, bit1 abort
//   out_data/valid/last/ready     AXIS readout packet
//   status_state                  0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT
//   missed_trigger                sticky: trigger seen while busy
module rx_triggered_capture #(
    parameter int DEPTH      = 2048,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  adc_clk,
    input  logic                  adc_reset_n,
    input  logic [DATA_WIDTH-1:0] adc_data_in,
    input  logic                  adc_valid_in,
    input  logic                  adc_trigger,
    input  logic [LEN_WIDTH-1:0]  cfg_length_data,
    input  logic                  cfg_length_valid,
    output logic                  cfg_length_ready,
    input  logic [1:0]            cfg_start_stop_data,
    input  logic                  cfg_start_stop_valid,
    output logic                  cfg_start_stop_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [1:0]            status_state,
    output logic                  missed_trigger
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t state, state_nx;

    logic                  ready_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  wr_cnt;   // words written; low bits are the write pointer
    logic [LEN_WIDTH-1:0]  rd_cnt;   // reads issued;  low bits are the read pointer
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // read-data stage, skid slot, output register form a short pipeline
    logic [DATA_WIDTH-1:0] rq_data, sk_data;
    logic                  rq_vld, rq_last, sk_vld, sk_last;

    logic       abort, arm, len_fire, wr_en, rd_en, pop;
    logic [1:0] occ;

    assign cfg_start_stop_ready = ready_q;
    assign cfg_length_ready     = ready_q && (state == S_IDLE);
    assign status_state         = state;

    assign abort    = cfg_start_stop_valid && ready_q && cfg_start_stop_data[1];
    assign arm      = cfg_start_stop_valid && ready_q && cfg_start_stop_data[0] && !cfg_start_stop_data[1];
    assign len_fire = cfg_length_valid && cfg_length_ready;
    assign pop      = out_valid && out_ready;

    // Slots still occupied after this cycle's pop. A new read is issued only
    // if its data is guaranteed a slot when it arrives, which still allows
    // one read per cycle while the consumer keeps popping.
    assign occ   = 2'(out_valid) + 2'(sk_vld) + 2'(rq_vld) - 2'(pop);
    assign rd_en = (state == S_READOUT) && !abort && (rd_cnt < len_q) && (occ < 2'd2);

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (arm) state_nx = S_ARMED;
                S_ARMED:   if (adc_trigger) begin
                               // trigger-cycle word is word 0
                               state_nx = S_CAPTURE;
                               wr_en    = adc_valid_in;
                           end
                S_CAPTURE: if (wr_cnt == len_q) begin
                               // only reachable when length 1 completed on the trigger cycle
                               state_nx = S_READOUT;
                           end else begin
                               wr_en = adc_valid_in;
                               if (adc_valid_in && (wr_cnt + ONE == len_q))
                                   state_nx = S_READOUT;
                           end
                S_READOUT: if (pop && out_last) state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!adc_reset_n) begin
            state          <= S_IDLE;
            ready_q        <= 1'b0;
            len_q          <= DEPTH_L;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            rq_vld         <= 1'b0;
            rq_last        <= 1'b0;
            sk_vld         <= 1'b0;
            sk_last        <= 1'b0;
            sk_data        <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
            missed_trigger <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= 1'b1;

            if (len_fire)
                len_q <= (cfg_length_data == '0 || cfg_length_data > DEPTH_L) ? DEPTH_L : cfg_length_data;

            if (state == S_IDLE && arm)
                missed_trigger <= 1'b0;
            else if ((state == S_CAPTURE || state == S_READOUT) && adc_trigger)
                missed_trigger <= 1'b1;

            if (abort || state_nx == S_IDLE || state_nx == S_ARMED)
                wr_cnt <= '0;
            else if (wr_en)
                wr_cnt <= wr_cnt + ONE;

            if (abort || state != S_READOUT)
                rd_cnt <= '0;
            else if (rd_en)
                rd_cnt <= rd_cnt + ONE;

            rq_vld  <= rd_en;
            rq_last <= rd_en && (rd_cnt == len_q - ONE);

            // output register is the head of a 2-entry queue; skid is the tail
            if (abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                sk_vld    <= 1'b0;
            end else if (pop || !out_valid) begin
                if (sk_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= sk_data;
                    out_last  <= sk_last;
                    sk_vld    <= rq_vld;
                    sk_data   <= rq_data;
                    sk_last   <= rq_last;
                end else begin
                    out_valid <= rq_vld;
                    out_last  <= rq_vld && rq_last;
                    if (rq_vld) out_data <= rq_data;
                end
            end else if (rq_vld) begin
                sk_vld  <= 1'b1;
                sk_data <= rq_data;
                sk_last <= rq_last;
            end
        end
    end

    // buffer: no reset so it maps onto block RAM; contents survive abort
    always_ff @(posedge adc_clk) begin
        if (wr_en && adc_reset_n)
            mem[wr_cnt[AW-1:0]] <= adc_data_in;
        if (rd_en)
            rq_data <= mem[rd_cnt[AW-1:0]];
    end

endmodule

// File: tb/tb_rx_triggered_capture.sv
// tb_rx_triggered_capture
//   Drives triggered capture bursts and checks the readout packets against a
//   reference that picks "the first L valid words from the trigger cycle on".
module tb_rx_triggered_capture;
    localparam int DEPTH = 2048;
    localparam int DW    = 256;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          adc_clk = 1'b0;
    logic          adc_reset_n = 1'b0;
    logic [DW-1:0] adc_data_in = '0;
    logic          adc_valid_in = 1'b0;
    logic          adc_trigger = 1'b0;
    logic [LW-1:0] cfg_length_data = '0;
    logic          cfg_length_valid = 1'b0;
    logic          cfg_length_ready;
    logic [1:0]    cfg_start_stop_data = '0;
    logic          cfg_start_stop_valid = 1'b0;
    logic          cfg_start_stop_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic [1:0]    status_state;
    logic          missed_trigger;

    rx_triggered_capture #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .adc_clk(adc_clk), .adc_reset_n(adc_reset_n),
        .adc_data_in(adc_data_in), .adc_valid_in(adc_valid_in), .adc_trigger(adc_trigger),
        .cfg_length_data(cfg_length_data), .cfg_length_valid(cfg_length_valid),
        .cfg_length_ready(cfg_length_ready),
        .cfg_start_stop_data(cfg_start_stop_data), .cfg_start_stop_valid(cfg_start_stop_valid),
        .cfg_start_stop_ready(cfg_start_stop_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .status_state(status_state), .missed_trigger(missed_trigger)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct { logic [DW-1:0] data; logic last; } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fails  = 0;
    int rdy_mode = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never
    int cyc      = 0;

    always @(posedge adc_clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk); #1;
    endtask

    // ready generator
    initial begin
        int pat = 0;
        forever begin
            @(posedge adc_clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // monitor: scoreboard pops, AXIS hold rules, throughput, first-word latency
    initial begin
        logic          pv_stall = 1'b0, plast = 1'b0, p_abort = 1'b1;
        logic          p_hs = 1'b0, p_hs_last = 1'b0, pend = 1'b0;
        logic [DW-1:0] pdata = '0;
        logic [1:0]    pstat = 2'd0;
        int            t3 = 0;
        exp_t          e;
        forever begin
            @(negedge adc_clk);
            if (adc_reset_n) begin
                if (pv_stall && !p_abort) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, pdata);
                    chk("hold_last", out_last, plast);
                end
                if (rdy_mode == 0 && p_hs && !p_hs_last && !p_abort)
                    chk("throughput", out_valid, 1);
                if (status_state != 2'd3)
                    chk("valid_outside_readout", out_valid, 0);
                if (status_state == 2'd3 && pstat != 2'd3) begin t3 = cyc; pend = 1'b1; end
                if (status_state != 2'd3) pend = 1'b0;
                if (pend && out_valid) begin
                    chk("first_valid_latency", cyc - t3, 2);
                    pend = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fails++;
                        $display("FAIL unexpected_word: got %0h with empty scoreboard", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("data", out_data, e.data);
                        chk("last", out_last, e.last);
                    end
                end
            end
            pv_stall  = out_valid && !out_ready;
            pdata     = out_data;
            plast     = out_last;
            p_abort   = !adc_reset_n || (cfg_start_stop_valid && cfg_start_stop_data[1]);
            p_hs      = out_valid && out_ready;
            p_hs_last = out_last;
            pstat     = status_state;
        end
    end

    task automatic set_len(input int v);
        cfg_length_data = LW'(v); cfg_length_valid = 1'b1;
        tick();
        cfg_length_valid = 1'b0;
    endtask

    task automatic ctrl(input logic [1:0] v);
        cfg_start_stop_data = v; cfg_start_stop_valid = 1'b1;
        tick();
        cfg_start_stop_valid = 1'b0;
    endtask

    task automatic wait_status(input logic [1:0] s, input string name);
        int n = 0;
        do begin @(negedge adc_clk); n++; end while (status_state != s && n < 20000);
        chk(name, status_state, s);
    endtask

    // Configure, arm, and feed the stream. The reference takes the first
    // `eff` valid words starting at the trigger cycle.
    task automatic stream(input int len_cfg, input int eff, input int gap, input int trig_at,
                          input int post, input bit mid_trig, input logic [DW-1:0] base);
        int            cap = 0, i = 0, p = post;
        bit            seen = 0, v;
        logic [DW-1:0] d = base;
        exp_t          e;
        tick();
        if (len_cfg >= 0) set_len(len_cfg);
        ctrl(2'b01);
        forever begin
            if (cap >= eff) begin
                if (p == 0) break;
                p--;
            end
            if (i > 20000) begin
                n_checks++; n_fails++;
                $display("FAIL stream_bound: captured %0d of %0d", cap, eff);
                break;
            end
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            adc_valid_in = v;
            adc_data_in  = d;
            adc_trigger  = (i == trig_at) || (mid_trig && i == trig_at + 1);
            if (i == trig_at) seen = 1;
            if (seen && v && cap < eff) begin
                e.data = d; e.last = (cap == eff - 1);
                sb.push_back(e);
                cap++;
            end
            if (v) d = d + 1;
            if (i == 0) begin
                @(negedge adc_clk);
                chk("armed_state", status_state, 1);
                chk("len_ready_busy", cfg_length_ready, 0);
                chk("arm_clears_missed", missed_trigger, 0);
            end
            tick();
            i++;
        end
        adc_valid_in = 1'b0;
        adc_trigger  = 1'b0;
    endtask

    task automatic burst(input int len_cfg, input int eff, input int gap, input int rmode,
                         input int trig_at, input int post, input bit mid_trig, input bit ro_trig,
                         input logic [DW-1:0] base);
        int n = 0;
        rdy_mode = rmode;
        stream(len_cfg, eff, gap, trig_at, post, mid_trig, base);
        if (ro_trig) begin
            wait_status(2'd3, "reach_readout");
            tick(); adc_trigger = 1'b1; tick(); adc_trigger = 1'b0;
        end
        do begin @(negedge adc_clk); n++; end
        while (!(status_state == 2'd0 && sb.size() == 0) && n < 20000);
        chk("back_to_idle", status_state, 0);
        chk("scoreboard_drained", sb.size(), 0);
        chk("missed_flag", missed_trigger, mid_trig || ro_trig);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        @(negedge adc_clk);
        chk("rst_len_ready", cfg_length_ready, 0);
        chk("rst_ss_ready", cfg_start_stop_ready, 0);
        chk("rst_status", status_state, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_missed", missed_trigger, 0);
        tick(); adc_reset_n = 1'b1; tick();
        @(negedge adc_clk);
        chk("len_ready_after_rst", cfg_length_ready, 1);
        chk("ss_ready_after_rst", cfg_start_stop_ready, 1);

        // length 4, trigger on 0xA2
        burst(4, 4, 0, 0, 2, 2, 0, 0, DW'(32'hA0));
        // length 3, gapped valid, ready 1,0,0,1
        burst(3, 3, 1, 1, 0, 1, 0, 0, DW'(32'hB0));
        // triggers during CAPTURE and READOUT
        burst(8, 8, 0, 2, 1, 0, 1, 1, DW'(32'hC0));
        // length 0 and out-of-range length both mean the full buffer
        burst(0, DEPTH, 0, 2, 0, 0, 0, 0, '0);
        burst(4095, DEPTH, 0, 0, 0, 0, 0, 0, '0);

        // abort mid-readout while stalled
        rdy_mode = 3;
        stream(5, 5, 0, 0, 0, 0, DW'(32'hD0));
        begin
            int n = 0;
            do begin @(negedge adc_clk); n++; end while (!out_valid && n < 200);
            chk("abort_valid_up", out_valid, 1);
        end
        tick();
        cfg_start_stop_data = 2'b10; cfg_start_stop_valid = 1'b1;
        @(negedge adc_clk);
        chk("abort_pre_valid", out_valid, 1);
        tick();
        cfg_start_stop_valid = 1'b0;
        @(negedge adc_clk);
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_idle", status_state, 0);
        sb.delete();
        burst(2, 2, 2, 2, 1, 1, 0, 0, DW'(32'hE0));

        // arm+abort together in IDLE stays IDLE; IDLE triggers are ignored
        tick();
        ctrl(2'b11);
        @(negedge adc_clk);
        chk("arm_abort_idle", status_state, 0);
        tick(); adc_trigger = 1'b1; tick(); adc_trigger = 1'b0; tick();
        @(negedge adc_clk);
        chk("idle_trigger_status", status_state, 0);
        chk("idle_trigger_missed", missed_trigger, 0);

        // randomized bursts
        for (int k = 0; k < 8; k++) begin
            int  l  = $urandom_range(1, 24);
            bit  mt = (l >= 2) && ($urandom_range(0, 1) == 1);
            bit  rt = (l >= 6) && ($urandom_range(0, 1) == 1);
            burst(l, l, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 3), mt, rt,
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end

        // reset during CAPTURE restores power-on state, including length
        tick();
        set_len(7);
        ctrl(2'b01);
        adc_valid_in = 1'b1; adc_data_in = DW'(32'hF0); adc_trigger = 1'b1;
        tick(); tick();
        adc_trigger = 1'b0;
        tick();
        @(negedge adc_clk);
        chk("capture_before_rst", status_state, 2);
        chk("missed_before_rst", missed_trigger, 1);
        tick(); adc_reset_n = 1'b0; tick();
        @(negedge adc_clk);
        chk("midrst_status", status_state, 0);
        chk("midrst_len_ready", cfg_length_ready, 0);
        chk("midrst_missed", missed_trigger, 0);
        chk("midrst_out_valid", out_valid, 0);
        tick(); adc_valid_in = 1'b0; adc_reset_n = 1'b1; tick();
        burst(-1, DEPTH, 0, 0, 0, 0, 0, 0, DW'(32'h1000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
